ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_host_tx_if.sv | 11 +
 rtl/ps2_sync_edge.sv | 28 ++
 rtl/ps2_host_tx.sv | 143 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, command constants and helpers for the host link
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  localparam int LED_SCROLL = 0;
  localparam int LED_NUM    = 1;
  localparam int LED_CAPS   = 2;

  // Whole microseconds to clock cycles; integer MHz assumed.
  function automatic int us_to_cycles(input int clk_hz, input int us);
    return clk_hz / 1000000 * us;
  endfunction

  // PS/2 frames carry odd parity over the data byte.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command-byte request/response handshake of the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output tx_data, tx_start, input busy, done, err);
  modport slave  (input tx_data, tx_start, output busy, done, err);
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 3-FF synchronisers for the PS/2 pins plus a device clock falling-edge detector
module ps2_sync_edge (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);
  logic [2:0] r_clk_sync;
  logic [2:0] r_data_sync;

  // Shift the raw pins in; reset to the released (high) level so no fall is seen after reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], ps2_clk_in};
      r_data_sync <= {r_data_sync[1:0], ps2_data_in};
    end
  end

  assign clk_s  = r_clk_sync[2];
  assign data_s = r_data_sync[2];
  assign fall   = r_clk_sync[2] & ~r_clk_sync[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with request-to-send, ACK check and timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 2000
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe,
  ps2_host_tx_if.slave   tx
);
  localparam int INHIBIT_CYCLES = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int TIMEOUT_CYCLES = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_parity, w_parity_nxt;
  logic          r_ack_ok, w_ack_ok_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          w_clk_s, w_data_s, w_fall;
  logic          w_timeout, w_bit_val;

  ps2_sync_edge u_sync (
    .clk         (clk),
    .clrn        (clrn),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_s       (w_clk_s),
    .data_s      (w_data_s),
    .fall        (w_fall)
  );

  // State and datapath registers; reset releases both lines at once since the oe pins decode state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_ack_ok <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_ack_ok <= w_ack_ok_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Next state, counters and line drive; the timeout wins over a fall in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 1'b1;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_ack_ok_nxt = r_ack_ok;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_timeout    = (r_state inside {REQ, DATA, ACK, WAIT_IDLE}) && (r_cnt == TO_LAST);
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_bit_nxt   = '0;
      w_err_nxt   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt = '0;
          w_bit_nxt = '0;
          if (tx.tx_start) begin
            w_state_nxt  = INHIBIT;
            w_shift_nxt  = tx.tx_data;
            w_parity_nxt = odd_parity(tx.tx_data);
          end
        end
        INHIBIT: begin
          if (r_cnt == INH_LAST) begin
            w_state_nxt = REQ;
            w_cnt_nxt   = '0;
          end
        end
        REQ: begin
          if (w_fall) begin
            w_state_nxt = DATA;
            w_bit_nxt   = 4'd1;
            w_cnt_nxt   = '0;
          end
        end
        DATA: begin
          if (w_fall) begin
            w_bit_nxt = r_bit + 4'd1;
            w_cnt_nxt = '0;
            if (r_bit == 4'd9) w_state_nxt = ACK;
          end
        end
        ACK: begin
          if (w_fall) begin
            w_state_nxt  = WAIT_IDLE;
            w_ack_ok_nxt = ~w_data_s;
            w_cnt_nxt    = '0;
          end
        end
        WAIT_IDLE: begin
          if (w_fall) w_cnt_nxt = '0;
          if (w_clk_s && w_data_s) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = r_ack_ok;
            w_err_nxt   = ~r_ack_ok;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    w_bit_val   = (r_bit == 4'd9) ? r_parity : r_shift[3'(r_bit - 4'd1)];
    ps2_clk_oe  = (r_state == INHIBIT);
    ps2_data_oe = ((r_state == INHIBIT) && (r_cnt == INH_LAST)) || (r_state == REQ) ||
                  ((r_state == DATA) && !w_bit_val);
  end

  assign tx.busy = (r_state != IDLE);
  assign tx.done = r_done;
  assign tx.err  = r_err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 device BFM with a frame/timing model checked every cycle
module tb_ps2_host_tx;
  localparam int F   = 4000000;
  localparam int IUS = 100;
  localparam int TUS = 200;
  localparam int N   = F / 1000000 * IUS;
  localparam int T   = F / 1000000 * TUS;
  localparam int H   = 20;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic clrn;
  logic ps2_clk_oe, ps2_data_oe;
  logic bfm_clk_low, bfm_data_low;
  wire  ps2_clk_in  = ~(ps2_clk_oe | bfm_clk_low);
  wire  ps2_data_in = ~(ps2_data_oe | bfm_data_low);

  ps2_host_tx_if bus ();

  ps2_host_tx #(.CLK_FREQ_HZ(F), .INHIBIT_US(IUS), .TIMEOUT_US(TUS)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx          (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passes = 0;
  bit m_active = 0;
  int inh_lo = -1, inh_hi = -2, req_lo = -1, req_hi = -2;
  int busy_lo = BIG, busy_hi = BIG, end_lo = BIG, end_hi = BIG;
  int n_done = 0, n_err = 0, err_cyc = 0, oe_cycles = 0;

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %b expected %b at cycle %0d", name, got, exp, cyc);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Frame as the device sees it: {stop, parity, d[7:0]}, odd parity from a ones count.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d};
  endfunction

  // Per-cycle comparison of DUT outputs against the model windows.
  always @(negedge clk) begin
    if (clrn) begin
      check_bit("clk_oe", ps2_clk_oe, (cyc >= inh_lo) && (cyc <= inh_hi));
      if (ps2_clk_oe) oe_cycles++;
      if ((cyc >= inh_lo) && (cyc <= inh_hi)) check_bit("data_oe_inhibit", ps2_data_oe, cyc == inh_hi);
      if ((cyc >= req_lo) && (cyc <= req_hi)) check_bit("data_oe_req", ps2_data_oe, 1'b1);
      if (!m_active) begin
        check_bit("idle_data_oe", ps2_data_oe, 1'b0);
        check_bit("idle_busy", bus.busy, 1'b0);
      end else if ((cyc >= busy_lo) && (cyc <= busy_hi)) check_bit("busy", bus.busy, 1'b1);
      check_bit("done_err_excl", bus.done & bus.err, 1'b0);
      if (m_active && (cyc >= end_lo) && (cyc <= end_hi)) begin
        if (bus.done | bus.err) begin
          n_done += int'(bus.done);
          n_err  += int'(bus.err);
          if (bus.err) err_cyc = cyc;
          check_bit("busy_at_end", bus.busy, 1'b0);
        end
      end else begin
        check_bit("no_done", bus.done, 1'b0);
        check_bit("no_err", bus.err, 1'b0);
      end
    end
  end

  task automatic wait_clk_oe(input logic v, input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ps2_clk_oe == v) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_bit("wait_clk_oe_bound", ps2_clk_oe, v);
  endtask

  task automatic issue(input logic [7:0] d, output int k);
    @(negedge clk);
    k = cyc;
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    n_done = 0;
    n_err = 0;
    oe_cycles = 0;
    inh_lo = k + 1;
    inh_hi = k + N;
    busy_lo = k + 1;
    busy_hi = BIG;
    end_lo = BIG;
    end_hi = BIG;
    m_active = 1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask

  // Device side: wait for the request, clock out 10 bits sampling before each rise, then the ACK slot.
  task automatic bfm_xfer(input bit ack, input int abort_bit, output logic [9:0] frame,
                          output int rel, output bit aborted);
    bit ok;
    frame = '0;
    rel = 0;
    aborted = 0;
    wait_clk_oe(1'b1, 50, ok);
    if (!ok) return;
    wait_clk_oe(1'b0, N + 50, ok);
    if (!ok) return;
    check_bit("start_bit", ps2_data_in, 1'b0);
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      bfm_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      if (i == abort_bit) begin
        aborted = 1;
        return;
      end
      frame[i-1] = ps2_data_in;
      bfm_clk_low = 1'b0;
      repeat (H) @(negedge clk);
    end
    if (ack) bfm_data_low = 1'b1;
    repeat (5) @(negedge clk);
    bfm_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    bfm_clk_low = 1'b0;
    bfm_data_low = 1'b0;
    rel = cyc;
  endtask

  task automatic finish_xfer(input bit ack, input int rel);
    end_lo = rel + 3;
    end_hi = rel + 5;
    busy_hi = rel + 2;
    repeat (8) @(negedge clk);
    check_int("done_count", n_done, ack ? 1 : 0);
    check_int("err_count", n_err, ack ? 0 : 1);
    m_active = 0;
    repeat (5) @(negedge clk);
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input bit use_pin,
                          input logic [9:0] pin, input bit second);
    int k, rel;
    bit ab;
    logic [9:0] frame;
    issue(d, k);
    fork
      bfm_xfer(ack, 0, frame, rel, ab);
      if (second) begin
        repeat (600) @(negedge clk);
        bus.tx_data  = 8'hFF;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
      end
    join
    if (frame !== model_frame(d)) $display("FAIL frame: got %h expected %h", frame, model_frame(d));
    checks++;
    if (frame === model_frame(d)) passes++;
    if (use_pin) begin
      checks++;
      if (frame === pin) passes++;
      else $display("FAIL frame_literal: got %h expected %h", frame, pin);
    end
    finish_xfer(ack, rel);
  endtask

  initial begin
    int k, rel;
    bit ab;
    logic [9:0] frame;
    clrn = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_data = 8'h00;
    bfm_clk_low = 1'b0;
    bfm_data_low = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_bit("rst_clk_oe", ps2_clk_oe, 1'b0);
    check_bit("rst_data_oe", ps2_data_oe, 1'b0);
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_done", bus.done, 1'b0);
    check_bit("rst_err", bus.err, 1'b0);
    @(negedge clk);
    #2 clrn = 1'b1;
    repeat (5) @(negedge clk);
    bfm_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    bfm_clk_low = 1'b0;
    repeat (10) @(negedge clk);

    run_xfer(8'hED, 1, 1, 10'h3ED, 0);
    check_int("inhibit_cycles_literal", oe_cycles, 400);
    run_xfer(8'h07, 1, 1, 10'h207, 0);
    run_xfer(8'h00, 1, 1, 10'h300, 0);
    run_xfer(8'($urandom), 0, 0, 10'h000, 0);
    run_xfer(8'h5A, 1, 1, 10'h35A, 1);

    issue(8'hA5, k);
    req_lo = k + N + 1;
    req_hi = k + N + T;
    busy_hi = k + N + T;
    end_lo = k + N + 1 + T;
    end_hi = k + N + 1 + T;
    repeat (N + T + 5) @(negedge clk);
    check_int("timeout_err", n_err, 1);
    check_int("timeout_no_done", n_done, 0);
    check_int("timeout_latency_literal", err_cyc - (k + N + 1), 800);
    check_bit("timeout_clk_oe", ps2_clk_oe, 1'b0);
    check_bit("timeout_data_oe", ps2_data_oe, 1'b0);
    m_active = 0;
    req_lo = -1;
    req_hi = -2;
    repeat (5) @(negedge clk);

    issue(8'h00, k);
    bfm_xfer(1, 4, frame, rel, ab);
    check_bit("bit4_data_oe", ps2_data_oe, 1'b1);
    #2 clrn = 1'b0;
    #1;
    check_bit("async_clk_oe", ps2_clk_oe, 1'b0);
    check_bit("async_data_oe", ps2_data_oe, 1'b0);
    check_bit("async_busy", bus.busy, 1'b0);
    m_active = 0;
    bfm_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    #2 clrn = 1'b1;
    repeat (5) @(negedge clk);
    run_xfer(8'h02, 1, 1, 10'h202, 0);

    for (int i = 0; i < 6; i++) run_xfer(8'($urandom), $urandom_range(3) != 0, 0, 10'h000, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
